// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: MD op codes, FSM states, default latencies.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MFX   = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational {HI,LO} result from latched op/operands, including signed overflow and divide-by-zero.
// MDU_DIV0_HOLD_EN: when defined, a zero divisor suppresses the HI/LO write instead of writing {A, all-ones}.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        result_wr
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic               div0;
    logic               ovf;

    assign a_sx = 64'($signed(a));
    assign b_sx = 64'($signed(b));
    assign div0 = (b == 32'd0);
    assign ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        result    = '0;
        result_wr = 1'b1;
        quot_s    = '0;
        rem_s     = '0;
        case (op)
            MD_MULT:  result = a_sx * b_sx;
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV, MD_DIVU: begin
                if (div0) begin
`ifdef MDU_DIV0_HOLD_EN
                    result_wr = 1'b0;
`else
                    result = {a, 32'hFFFF_FFFF};
`endif
                end else if (op == MD_DIVU) begin
                    result = {a % b, a / b};
                end else if (ovf) begin
                    // Quotient wraps to the dividend; the remainder is exactly zero.
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    quot_s = $signed(a) / $signed(b);
                    rem_s  = $signed(a) % $signed(b);
                    result = {rem_s, quot_s};
                end
            end
            default: result_wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: HI/LO ownership, fixed-latency busy counter and D-stage stall request.
// Optional MDU_DIV0_HOLD_EN (see mdu_arith) keeps HI/LO unchanged on divide-by-zero.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic        E_Start,
    input  logic        E_HiLoSel,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_IsMD,
    output logic [31:0] E_MDOut,
    output logic        E_Busy,
    output logic        D_MDStall
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [63:0]       res;
    logic              res_wr;

    mdu_arith u_arith (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .result    (res),
        .result_wr (res_wr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (E_Start) begin
                    if (is_arith(E_MDOp)) begin
                        op_d    = E_MDOp;
                        a_d     = E_A;
                        b_d     = E_B;
                        cnt_d   = ((E_MDOp == MD_MULT) || (E_MDOp == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                        state_d = ST_BUSY;
                    end else if (E_MDOp == MD_MTHI) begin
                        hi_d = E_A;
                    end else if (E_MDOp == MD_MTLO) begin
                        lo_d = E_A;
                    end
                end
            end
            ST_BUSY: begin
                // New starts are ignored here; the stall keeps them from arriving legally.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (res_wr) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign E_Busy    = (state_q == ST_BUSY);
    assign D_MDStall = D_IsMD && (E_Busy || (E_Start && is_arith(E_MDOp)));
    assign E_MDOut   = E_HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + randomized checks of mdu_ctrl against an arithmetic HI/LO reference model.
module tb_mdu_ctrl;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_MDOp;
    logic        E_Start;
    logic        E_HiLoSel;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_IsMD;
    logic [31:0] E_MDOut;
    logic        E_Busy;
    logic        D_MDStall;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] hi_m, lo_m;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDOp    (E_MDOp),
        .E_Start   (E_Start),
        .E_HiLoSel (E_HiLoSel),
        .E_A       (E_A),
        .E_B       (E_B),
        .D_IsMD    (D_IsMD),
        .E_MDOut   (E_MDOut),
        .E_Busy    (E_Busy),
        .D_MDStall (D_MDStall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        E_HiLoSel = 1'b1;
        #1;
        chk({tag, "_hi"}, E_MDOut, hi_m);
        E_HiLoSel = 1'b0;
        #1;
        chk({tag, "_lo"}, E_MDOut, lo_m);
    endtask

    // Reference: what HI/LO should hold after an op completes.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin p = 64'(a) * 64'(b); hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
`ifndef MDU_DIV0_HOLD_EN
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
`endif
                end else if (op == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = 32'(q);
                    hi_m = 32'(r);
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle, hammer the unit with illegal starts while busy, then check latency and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int exp_cyc, n;
        logic arith;
        arith   = (op >= 3'd1) && (op <= 3'd4);
        exp_cyc = !arith ? 0 : (op <= 3'd2) ? N_MULT : N_DIV;
        E_MDOp  = op;
        E_A     = a;
        E_B     = b;
        E_Start = 1'b1;
        D_IsMD  = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_stall_issue"}, 32'(D_MDStall), 32'(D_IsMD && arith));
        step();
        n = 0;
        while (E_Busy && n < 40) begin
            n++;
            D_IsMD  = 1'b1;
            E_Start = 1'b1;
            E_MDOp  = 3'($urandom_range(1, 6));
            E_A     = $urandom;
            E_B     = $urandom;
            #1;
            chk({tag, "_stall_busy"}, 32'(D_MDStall), 32'd1);
            step();
        end
        E_Start = 1'b0;
        E_MDOp  = 3'd0;
        D_IsMD  = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
        model(op, a, b);
        check_hilo(tag);
    endtask

    initial begin
        reset     = 1'b0;
        E_MDOp    = 3'd0;
        E_Start   = 1'b0;
        E_HiLoSel = 1'b0;
        E_A       = '0;
        E_B       = '0;
        D_IsMD    = 1'b0;
        hi_m      = '0;
        lo_m      = '0;
        step();
        step();
        reset = 1'b1;
        step();

        D_IsMD = 1'b1;
        #1;
        chk("rst_busy", 32'(E_Busy), 32'd0);
        chk("rst_stall", 32'(D_MDStall), 32'd0);
        D_IsMD = 1'b0;
        check_hilo("rst");

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_hi_const", hi_m, 32'hFFFF_FFFF);
        chk("mult_neg_lo_const", lo_m, 32'hFFFF_FFFA);
        run_op("divu", 3'd4, 32'd100, 32'd7);
        chk("divu_const", {hi_m[15:0], lo_m[15:0]}, {16'd2, 16'd14});
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", lo_m, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", lo_m, 32'h8000_0000);
        run_op("div0", 3'd3, 32'd5, 32'd0);
        run_op("divu0", 3'd4, 32'hDEAD_BEEF, 32'd0);
        run_op("mthi", 3'd5, 32'h0000_1234, 32'd0);
        chk("mthi_const", hi_m, 32'h0000_1234);
        run_op("mtlo", 3'd6, 32'hCAFE_0001, 32'd0);
        run_op("mfx", 3'd7, 32'h1111_1111, 32'h2222_2222);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op("rand", 3'($urandom_range(1, 7)), $urandom, rb);
        end

        // Reset during a multiply must discard it entirely.
        E_MDOp  = 3'd1;
        E_A     = 32'h1234_5678;
        E_B     = 32'h9ABC_DEF0;
        E_Start = 1'b1;
        step();
        E_Start = 1'b0;
        E_MDOp  = 3'd0;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        hi_m  = '0;
        lo_m  = '0;
        chk("midrst_busy", 32'(E_Busy), 32'd0);
        check_hilo("midrst");
        for (int i = 0; i < 8; i++) step();
        chk("midrst_late_busy", 32'(E_Busy), 32'd0);
        check_hilo("midrst_late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
